mlp_stream_sequencer: RTL and testbench

//  Host-side sequencer directly upstream/downstream of the mlp core's register port.
//  - Consumes a weight stream and an input-vector stream (valid/ready).
//  - Drives the core's write_en/addr/writedata bus: weight push, layer switch, input push, RUN.
//  - Waits for irq, reads back N_OUTPUT results and emits them on a valid/ready result stream.

---
 rtl/mlp_pkg.sv | 48 ++++
 rtl/mlp_stream_sequencer_if.sv | 36 +++
 rtl/mlp_bus_writer.sv | 47 ++++
 rtl/mlp_stream_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_mlp_stream_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_pkg.sv
// Shared constants, register map and state type for the mlp host sequencer.
package mlp_pkg;

    localparam int unsigned N_INPUTS  = 2;
    localparam int unsigned N_HIDDEN  = 4;
    localparam int unsigned N_OUTPUT  = 1;
    localparam int unsigned IN_WIDTH  = 16;
    localparam int unsigned WGT_WIDTH = 16;
    localparam int unsigned OUT_WIDTH = 16;

    // Words per layer: each neuron takes a bias followed by one weight per input.
    localparam int unsigned NH_W = N_HIDDEN * (N_INPUTS + 1);
    localparam int unsigned NO_W = N_OUTPUT * (N_HIDDEN + 1);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_INPUT  = 2'd1;
    localparam logic [1:0] ADDR_WEIGHT = 2'd2;
    localparam logic [1:0] ADDR_OUTPUT = 2'd3;

    localparam int unsigned CTRL_RUN   = 0;
    localparam int unsigned CTRL_DONE  = 1;
    localparam int unsigned CTRL_LAYER = 3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WLOAD,
        S_WLAYER,
        S_XLOAD,
        S_RUN,
        S_WAIT,
        S_RSEL,
        S_RCAP,
        S_EMIT,
        S_CLEAR
    } state_t;

    // CTRL register value; DONE is read-only in the core so it is never set here.
    function automatic logic [31:0] ctrl_word(input logic run, input logic layer);
        logic [31:0] w;
        w = '0;
        w[CTRL_RUN]   = run;
        w[CTRL_LAYER] = layer;
        return w;
    endfunction

endpackage

// File: rtl/mlp_stream_sequencer_if.sv
// Stream and core-register-port signals of the mlp sequencer.
interface mlp_stream_sequencer_if;
    import mlp_pkg::*;

    logic                 wgt_valid;
    logic                 wgt_ready;
    logic [WGT_WIDTH-1:0] wgt_data;
    logic                 x_valid;
    logic                 x_ready;
    logic [IN_WIDTH-1:0]  x_data;
    logic                 y_valid;
    logic                 y_ready;
    logic [OUT_WIDTH-1:0] y_data;
    logic                 y_last;
    logic                 wgt_loaded;
    logic                 mlp_we;
    logic [1:0]           mlp_addr;
    logic [31:0]          mlp_wdata;
    logic [31:0]          mlp_rdata;
    logic                 mlp_irq;

    // Sequencer side.
    modport master (
        input  wgt_valid, wgt_data, x_valid, x_data, y_ready, mlp_rdata, mlp_irq,
        output wgt_ready, x_ready, y_valid, y_data, y_last, wgt_loaded,
        mlp_we, mlp_addr, mlp_wdata
    );

    // Stream producer/consumer and core side.
    modport slave (
        output wgt_valid, wgt_data, x_valid, x_data, y_ready, mlp_rdata, mlp_irq,
        input  wgt_ready, x_ready, y_valid, y_data, y_last, wgt_loaded,
        mlp_we, mlp_addr, mlp_wdata
    );

endinterface

// File: rtl/mlp_bus_writer.sv
// Single-cycle core write strobe; busy while the strobe is on the bus.
module mlp_bus_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  addr_in,
    input  logic [31:0] wdata_in,
    output logic        we,
    output logic [1:0]  addr,
    output logic [31:0] wdata,
    output logic        busy
);

    logic        we_q, we_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    // A start while the strobe is up is ignored so we never stays high two cycles.
    always_comb begin
        we_d    = start && !we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (we_d) begin
            addr_d  = addr_in;
            wdata_d = wdata_in;
        end
    end

    // Strobe and bus registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we    = we_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;
    assign busy  = we_q;

endmodule

// File: rtl/mlp_stream_sequencer.sv
// Host sequencer: streams weights and inputs into the mlp core, starts it,
// waits for DONE and returns the results on a valid/ready stream.
module mlp_stream_sequencer
    import mlp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    mlp_stream_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0] WCNT_LAYER = CNT_W'(NH_W);
    localparam logic [CNT_W-1:0] WCNT_DONE  = CNT_W'(NH_W + NO_W);
    localparam logic [CNT_W-1:0] XCNT_LAST  = CNT_W'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0] K_LAST     = CNT_W'(N_OUTPUT - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     wcnt_q, wcnt_d;
    logic [CNT_W-1:0]     xcnt_q, xcnt_d;
    logic [CNT_W-1:0]     k_q, k_d;
    logic [OUT_WIDTH-1:0] y_data_q, y_data_d;
    logic                 y_valid_q, y_valid_d;
    logic                 y_last_q, y_last_d;
    logic                 wgt_loaded_q, wgt_loaded_d;

    logic                 wr_start;
    logic [1:0]           wr_addr;
    logic [31:0]          wr_data;
    logic                 wr_busy;
    logic                 wgt_ready_c;
    logic                 x_ready_c;
    logic                 unused_rdata_hi;

    assign unused_rdata_hi = ^bus.mlp_rdata[31:OUT_WIDTH];

    mlp_bus_writer u_writer (
        .clk      (clk),
        .rst      (rst),
        .start    (wr_start),
        .addr_in  (wr_addr),
        .wdata_in (wr_data),
        .we       (bus.mlp_we),
        .addr     (bus.mlp_addr),
        .wdata    (bus.mlp_wdata),
        .busy     (wr_busy)
    );

    // Next-state, counters, stream handshakes and write requests.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        xcnt_d       = xcnt_q;
        k_d          = k_q;
        y_data_d     = y_data_q;
        y_valid_d    = y_valid_q;
        y_last_d     = y_last_q;
        wgt_loaded_d = wgt_loaded_q;
        wr_start     = 1'b0;
        wr_addr      = ADDR_CTRL;
        wr_data      = '0;
        wgt_ready_c  = 1'b0;
        x_ready_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = wgt_loaded_q ? S_XLOAD : S_WLOAD;
            end
            S_WLOAD: begin
                wgt_ready_c = !wr_busy;
                if (bus.wgt_valid && !wr_busy) begin
                    wr_start = 1'b1;
                    wr_addr  = ADDR_WEIGHT;
                    wr_data  = {{(32-WGT_WIDTH){bus.wgt_data[WGT_WIDTH-1]}}, bus.wgt_data};
                    wcnt_d   = wcnt_q + 1'b1;
                    if (wcnt_d == WCNT_LAYER) begin
                        state_d = S_WLAYER;
                    end else if (wcnt_d == WCNT_DONE) begin
                        wgt_loaded_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
            end
            S_WLAYER: begin
                if (!wr_busy) begin
                    wr_start = 1'b1;
                    wr_addr  = ADDR_CTRL;
                    wr_data  = ctrl_word(1'b0, 1'b1);
                    state_d  = S_WLOAD;
                end
            end
            S_XLOAD: begin
                x_ready_c = !wr_busy;
                if (bus.x_valid && !wr_busy) begin
                    wr_start = 1'b1;
                    wr_addr  = ADDR_INPUT;
                    wr_data  = {{(32-IN_WIDTH){bus.x_data[IN_WIDTH-1]}}, bus.x_data};
                    if (xcnt_q == XCNT_LAST) begin
                        xcnt_d  = '0;
                        state_d = S_RUN;
                    end else begin
                        xcnt_d = xcnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!wr_busy) begin
                    wr_start = 1'b1;
                    wr_addr  = ADDR_CTRL;
                    wr_data  = ctrl_word(1'b1, 1'b0);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mlp_irq) begin
                    k_d     = '0;
                    state_d = S_RSEL;
                end
            end
            S_RSEL: begin
                if (!wr_busy) begin
                    wr_start = 1'b1;
                    wr_addr  = ADDR_OUTPUT;
                    wr_data  = {{(32-CNT_W){1'b0}}, k_q};
                    state_d  = S_RCAP;
                end
            end
            S_RCAP: begin
                // Readdata reflects the new index only once the select write has landed.
                if (!wr_busy) begin
                    y_data_d  = bus.mlp_rdata[OUT_WIDTH-1:0];
                    y_valid_d = 1'b1;
                    y_last_d  = (k_q == K_LAST);
                    state_d   = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.y_ready) begin
                    y_valid_d = 1'b0;
                    y_last_d  = 1'b0;
                    if (k_q == K_LAST) begin
                        state_d = S_CLEAR;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_RSEL;
                    end
                end
            end
            S_CLEAR: begin
                if (!wr_busy) begin
                    wr_start = 1'b1;
                    wr_addr  = ADDR_CTRL;
                    wr_data  = ctrl_word(1'b0, 1'b0);
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            xcnt_q       <= '0;
            k_q          <= '0;
            y_data_q     <= '0;
            y_valid_q    <= 1'b0;
            y_last_q     <= 1'b0;
            wgt_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            xcnt_q       <= xcnt_d;
            k_q          <= k_d;
            y_data_q     <= y_data_d;
            y_valid_q    <= y_valid_d;
            y_last_q     <= y_last_d;
            wgt_loaded_q <= wgt_loaded_d;
        end
    end

    assign bus.wgt_ready  = wgt_ready_c;
    assign bus.x_ready    = x_ready_c;
    assign bus.y_valid    = y_valid_q;
    assign bus.y_data     = y_data_q;
    assign bus.y_last     = y_last_q;
    assign bus.wgt_loaded = wgt_loaded_q;

endmodule

// File: tb/tb_mlp_stream_sequencer.sv
// Bench for mlp_stream_sequencer with a behavioural mlp core on the register port
// and a scoreboard of expected results.
module tb_mlp_stream_sequencer;
    import mlp_pkg::*;

    localparam int NW  = NH_W + NO_W;
    localparam int LAT = 8;

    typedef struct {
        logic [OUT_WIDTH-1:0] data;
        logic                 last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mlp_stream_sequencer_if bus();

    mlp_stream_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Bench-side weight set and scoreboard.
    int   gw[NW];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   y_mode = 0;
    logic rst_at_edge = 1'b1;

    // Core model state.
    int   cw[NW];
    int   cx[N_INPUTS];
    int   core_res[N_OUTPUT];
    int   core_sel = 0, core_wh = 0, core_wo = 0, core_xc = 0, core_cd = 0, core_lsw = 0;
    logic core_done = 1'b0, core_layer = 1'b0;

    function automatic int relu(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    // Behavioural MLP: per neuron bias then weights, hidden layer first, ReLU on both layers.
    function automatic int ref_out(input int k, input int w[NW], input int x[N_INPUTS]);
        int h[N_HIDDEN];
        int acc;
        int base;
        for (int j = 0; j < N_HIDDEN; j++) begin
            base = j * (N_INPUTS + 1);
            acc  = w[base];
            for (int i = 0; i < N_INPUTS; i++) acc += w[base + 1 + i] * x[i];
            h[j] = relu(acc);
        end
        base = NH_W + k * (N_HIDDEN + 1);
        acc  = w[base];
        for (int j = 0; j < N_HIDDEN; j++) acc += w[base + 1 + j] * h[j];
        return relu(acc);
    endfunction

    assign bus.mlp_irq   = core_done;
    assign bus.mlp_rdata = (core_sel < N_OUTPUT) ? 32'(core_res[core_sel]) : 32'hdead_beef;

    // Behavioural core: register writes, fixed compute latency after RUN.
    always @(posedge clk) begin
        rst_at_edge <= rst;
        if (rst) begin
            core_wh <= 0; core_wo <= 0; core_xc <= 0; core_sel <= 0;
            core_cd <= 0; core_lsw <= 0; core_done <= 1'b0; core_layer <= 1'b0;
        end else begin
            if (core_cd == 1) begin
                for (int k = 0; k < N_OUTPUT; k++) core_res[k] <= ref_out(k, cw, cx);
                core_done <= 1'b1;
            end
            if (core_cd != 0) core_cd <= core_cd - 1;
            if (bus.mlp_we) begin
                case (bus.mlp_addr)
                    ADDR_WEIGHT: begin
                        if (!core_layer) begin
                            if (core_wh < NH_W) cw[core_wh] <= $signed(bus.mlp_wdata);
                            core_wh <= core_wh + 1;
                        end else begin
                            if (core_wo < NO_W) cw[NH_W + core_wo] <= $signed(bus.mlp_wdata);
                            core_wo <= core_wo + 1;
                        end
                    end
                    ADDR_INPUT: begin
                        if (core_xc < N_INPUTS) cx[core_xc] <= $signed(bus.mlp_wdata);
                        core_xc <= core_xc + 1;
                    end
                    ADDR_OUTPUT: core_sel <= int'(bus.mlp_wdata);
                    default: begin
                        if (bus.mlp_wdata[CTRL_LAYER]) begin
                            core_layer <= 1'b1;
                            core_lsw   <= core_lsw + 1;
                        end
                        if (bus.mlp_wdata[CTRL_RUN]) core_cd <= LAT;
                        if (bus.mlp_wdata == 32'h0) begin
                            core_done  <= 1'b0;
                            core_layer <= 1'b0;
                            core_xc    <= 0;
                        end
                    end
                endcase
            end
        end
    end

    // Downstream ready pattern: 0 always ready, 1 random, 2 held low.
    always @(posedge clk) begin
        #1;
        case (y_mode)
            0:       bus.y_ready = 1'b1;
            1:       bus.y_ready = 1'($urandom_range(0, 1));
            default: bus.y_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    logic       prev_we = 1'b0;
    logic       prev_stall = 1'b0;
    logic [OUT_WIDTH-1:0] prev_y = '0;
    int         ld_cnt = 0;
    exp_t       e;

    // Monitor: all comparisons happen here, away from the active edge.
    always @(negedge clk) begin
        if (rst_at_edge) begin
            chk("reset_outputs",
                64'({bus.wgt_ready, bus.x_ready, bus.y_valid, bus.y_data, bus.y_last,
                     bus.wgt_loaded, bus.mlp_we, bus.mlp_addr, bus.mlp_wdata}), 64'h0);
            sb.delete();
            prev_we    = 1'b0;
            prev_stall = 1'b0;
            ld_cnt     = 0;
        end else begin
            if (bus.y_valid && bus.y_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL y_unexpected: actual=%0d required=none at %0t", bus.y_data, $time);
                end else begin
                    e = sb.pop_front();
                    chk("y_data", 64'(bus.y_data), 64'(e.data));
                    chk("y_last", 64'(bus.y_last), 64'(e.last));
                end
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(bus.y_valid), 64'd1);
                chk("stall_data", 64'(bus.y_data), 64'(prev_y));
            end
            if (bus.y_valid) chk("we_during_emit", 64'(bus.mlp_we), 64'd0);
            if (bus.x_ready || bus.wgt_ready)
                chk("ready_rules",
                    64'({bus.x_ready && bus.wgt_ready, bus.x_ready && !bus.wgt_loaded,
                         bus.x_ready && core_done}), 64'd0);
            if (bus.mlp_we) begin
                chk("we_one_cycle", 64'(prev_we), 64'd0);
                if (bus.mlp_addr == ADDR_CTRL && bus.mlp_wdata == 32'h8)
                    chk("layer_switch_pos", {32'(core_wh), 32'(core_wo)}, {32'(NH_W), 32'd0});
                if (bus.mlp_addr == ADDR_CTRL && bus.mlp_wdata == 32'h1)
                    chk("run_after_inputs", 64'(core_xc), 64'(N_INPUTS));
            end
            if (bus.wgt_loaded) begin
                if (ld_cnt == 1) begin
                    chk("weight_count", {32'(core_wh), 32'(core_wo)}, {32'(NH_W), 32'(NO_W)});
                    chk("layer_switch_count", 64'(core_lsw), 64'd1);
                    for (int i = 0; i < NW; i++) chk("weight_word", 64'(cw[i]), 64'(gw[i]));
                end
                if (ld_cnt < 3) ld_cnt++;
            end else begin
                ld_cnt = 0;
            end
            prev_we    = bus.mlp_we;
            prev_stall = bus.y_valid && !bus.y_ready;
            prev_y     = bus.y_data;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int d, input int gap);
        logic acc;
        repeat (gap) cycle();
        bus.wgt_valid = 1'b1;
        bus.wgt_data  = WGT_WIDTH'(d);
        for (int t = 0; ; t++) begin
            @(negedge clk);
            acc = bus.wgt_ready;
            cycle();
            if (acc) break;
            if (t > 500) begin
                $display("FAIL wgt_handshake_timeout: no wgt_ready within 500 cycles");
                $fatal(1);
            end
        end
        bus.wgt_valid = 1'b0;
    endtask

    task automatic load_weights(input bit gaps);
        for (int i = 0; i < NW; i++) send_word(gw[i], gaps ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic push_const(input int v);
        exp_t x;
        x.data = OUT_WIDTH'(v);
        x.last = 1'b1;
        sb.push_back(x);
    endtask

    task automatic push_model(input int x[N_INPUTS]);
        exp_t p;
        for (int k = 0; k < N_OUTPUT; k++) begin
            p.data = OUT_WIDTH'(ref_out(k, gw, x));
            p.last = (k == N_OUTPUT - 1);
            sb.push_back(p);
        end
    endtask

    task automatic send_vector(input int x[N_INPUTS], input bit toggle);
        logic acc;
        logic phase;
        for (int i = 0; i < N_INPUTS; i++) begin
            phase = 1'b1;
            for (int t = 0; ; t++) begin
                bus.x_valid = toggle ? phase : 1'b1;
                bus.x_data  = IN_WIDTH'(x[i]);
                @(negedge clk);
                acc = bus.x_valid && bus.x_ready;
                cycle();
                phase = !phase;
                if (acc) break;
                if (t > 1000) begin
                    $display("FAIL x_handshake_timeout: no x_ready within 1000 cycles");
                    $fatal(1);
                end
            end
            bus.x_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; ; t++) begin
            if (sb.size() == 0 && !bus.y_valid) break;
            if (t > 3000) begin
                $display("FAIL drain_timeout: %0d results outstanding", sb.size());
                $fatal(1);
            end
            cycle();
        end
        repeat (4) cycle();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    int xv[N_INPUTS];
    bit found;

    initial begin
        bus.wgt_valid = 1'b0;
        bus.wgt_data  = '0;
        bus.x_valid   = 1'b0;
        bus.x_data    = '0;
        repeat (2) cycle();
        rst = 1'b0;

        // Reference network and two directed vectors.
        gw = '{1, 2, 3,  0, -1, 2,  -2, 4, 1,  1, 1, 1,  1, 1, 1, 1, 1};
        load_weights(1'b0);
        xv = '{7, -3};
        push_const(35);
        send_vector(xv, 1'b0);
        wait_drain();
        xv = '{-100, -100};
        push_const(1);
        send_vector(xv, 1'b0);
        wait_drain();

        // Downstream stalled for 20 cycles with a result pending.
        y_mode = 2;
        xv = '{7, -3};
        push_const(35);
        send_vector(xv, 1'b0);
        for (int t = 0; !bus.y_valid; t++) begin
            if (t > 500) begin
                $display("FAIL y_valid_timeout: no result within 500 cycles");
                $fatal(1);
            end
            cycle();
        end
        repeat (20) cycle();
        y_mode = 0;
        wait_drain();

        // Toggling x_valid and random downstream backpressure.
        y_mode = 1;
        for (int v = 0; v < 25; v++) begin
            for (int i = 0; i < N_INPUTS; i++) xv[i] = int'($urandom_range(0, 120)) - 60;
            push_model(xv);
            send_vector(xv, 1'b1);
        end
        wait_drain();

        // Reset while the core is computing; the pending result is discarded.
        y_mode = 0;
        xv = '{5, 9};
        push_model(xv);
        send_vector(xv, 1'b0);
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            found = bus.mlp_we && bus.mlp_addr == ADDR_CTRL && bus.mlp_wdata == 32'h1;
        end
        if (!found) begin
            $display("FAIL run_write_timeout: no RUN write within 200 cycles");
            $fatal(1);
        end
        cycle();
        pulse_reset();
        repeat (2) cycle();
        load_weights(1'b1);
        xv = '{7, -3};
        push_const(35);
        send_vector(xv, 1'b0);
        wait_drain();

        // Fresh random weight set after another reset.
        pulse_reset();
        repeat (2) cycle();
        for (int i = 0; i < NW; i++) gw[i] = int'($urandom_range(0, 8)) - 4;
        load_weights(1'b1);
        y_mode = 1;
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < N_INPUTS; i++) xv[i] = int'($urandom_range(0, 100)) - 50;
            push_model(xv);
            send_vector(xv, 1'($urandom_range(0, 1)));
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
